// File: rtl/player_anim_pkg.sv
// Shared animation table and state types for the player sprite engine.
// Each animation's frames are packed back to back in the sprite ROM starting at ANIM_BASE.
package player_anim_pkg;

    localparam int NUM_ANIM_TBL = 8;

    typedef enum logic [2:0] {
        WAIT,
        RUN,
        DOWN,
        UP,
        DOWN_RL,
        UP_RL,
        JUMP,
        DEAD
    } anim_e;

    typedef enum logic {
        PLAY,
        HOLD
    } seq_state_e;

    // ANIM_BASE[a+1] = ANIM_BASE[a] + NFRAMES[a] * W[a] * H[a]
    localparam int unsigned ANIM_BASE    [NUM_ANIM_TBL] = '{0, 3072, 7680, 8704, 12288, 14848, 19328, 27520};
    localparam int unsigned ANIM_NFRAMES [NUM_ANIM_TBL] = '{2, 3, 1, 2, 2, 2, 4, 4};
    localparam int unsigned ANIM_W       [NUM_ANIM_TBL] = '{32, 32, 32, 32, 40, 40, 32, 48};
    localparam int unsigned ANIM_H       [NUM_ANIM_TBL] = '{48, 48, 32, 56, 32, 56, 64, 32};
    localparam bit          ANIM_LOOP    [NUM_ANIM_TBL] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

endpackage

// File: rtl/anim_frame_seq.sv
// Frame sequencer: frame_clk edge detect, tick divider, frame counter and PLAY/HOLD FSM.
// A change of requested animation always restarts from frame 0 and beats a same-cycle tick.
module anim_frame_seq
    import player_anim_pkg::*;
#(
    parameter  int NUM_ANIMS  = 8,
    parameter  int MAX_FRAMES = 4,
    parameter  int FRAME_DIV  = 6,
    localparam int AW = (NUM_ANIMS  > 1) ? $clog2(NUM_ANIMS)  : 1,
    localparam int FW = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1,
    localparam int DW = (FRAME_DIV  > 1) ? $clog2(FRAME_DIV)  : 1
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          i_frameClk,
    input  logic [AW-1:0] i_animSel,
    input  logic          i_moving,
    output logic [AW-1:0] o_anim,
    output logic [FW-1:0] o_frameIdx,
    output logic          o_animDone
);

    seq_state_e    r_state;
    seq_state_e    w_stateNext;
    logic          r_frameClkQ;
    logic          w_tick;
    logic [AW-1:0] r_anim;
    logic [AW-1:0] w_animNext;
    logic [FW-1:0] r_frame;
    logic [FW-1:0] w_frameNext;
    logic [FW-1:0] w_lastFrame;
    logic [DW-1:0] r_div;
    logic [DW-1:0] w_divNext;
    logic          w_loop;
    logic          w_advance;

    assign w_tick      = i_frameClk & ~r_frameClkQ;
    assign w_lastFrame = FW'(ANIM_NFRAMES[r_anim] - 1);
    assign w_loop      = ANIM_LOOP[r_anim];
    // Looping poses (run, crawl) only animate while the player is moving; one-shots always play out.
    assign w_advance   = (w_loop & i_moving) | ~w_loop;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_frameClkQ <= 1'b0;
            r_state     <= PLAY;
            r_anim      <= '0;
            r_frame     <= '0;
            r_div       <= '0;
        end else begin
            r_frameClkQ <= i_frameClk;
            r_state     <= w_stateNext;
            r_anim      <= w_animNext;
            r_frame     <= w_frameNext;
            r_div       <= w_divNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_animNext  = r_anim;
        w_frameNext = r_frame;
        w_divNext   = r_div;
        if (i_animSel != r_anim) begin
            w_animNext  = i_animSel;
            w_frameNext = '0;
            w_divNext   = '0;
            w_stateNext = PLAY;
        end else begin
            case (r_state)
                PLAY: begin
                    if (w_tick && w_advance) begin
                        if (r_div == DW'(FRAME_DIV - 1)) begin
                            w_divNext = '0;
                            if (w_loop) begin
                                w_frameNext = (r_frame == w_lastFrame) ? '0 : r_frame + FW'(1);
                            end else if (r_frame == w_lastFrame) begin
                                w_stateNext = HOLD;
                            end else begin
                                w_frameNext = r_frame + FW'(1);
                                if (r_frame + FW'(1) == w_lastFrame) begin
                                    w_stateNext = HOLD;
                                end
                            end
                        end else begin
                            w_divNext = r_div + DW'(1);
                        end
                    end
                end
                HOLD: begin
                    w_stateNext = HOLD;
                end
                default: begin
                    w_stateNext = PLAY;
                end
            endcase
        end
    end

    assign o_anim     = r_anim;
    assign o_frameIdx = r_frame;
    assign o_animDone = (r_state == HOLD);

endmodule

// File: rtl/player_sprite_animator.sv
// Player sprite engine: table lookup, sprite-box hit test, horizontal mirror and ROM address generation.
// Address and spriteOn are registered once, so they trail DrawX/DrawY by one Clk.
module player_sprite_animator
    import player_anim_pkg::*;
#(
    parameter  int NUM_ANIMS  = 8,
    parameter  int MAX_FRAMES = 4,
    parameter  int FRAME_DIV  = 6,
    parameter  int ADDR_W     = 21,
    parameter  int COORD_W    = 10,
    localparam int AW = (NUM_ANIMS  > 1) ? $clog2(NUM_ANIMS)  : 1,
    localparam int FW = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               frame_clk,
    input  logic [AW-1:0]      anim_sel,
    input  logic               moving,
    input  logic               direction,
    input  logic [COORD_W-1:0] DrawX,
    input  logic [COORD_W-1:0] DrawY,
    input  logic [COORD_W-1:0] PlayerX,
    input  logic [COORD_W-1:0] PlayerY,
    output logic [ADDR_W-1:0]  spriteAddress,
    output logic               spriteOn,
    output logic [COORD_W-1:0] PlayerWidth,
    output logic [COORD_W-1:0] PlayerHeight,
    output logic [FW-1:0]      frameIdx,
    output logic               animDone
);

    localparam int CW1 = COORD_W + 1;

    logic [AW-1:0]      w_anim;
    logic [CW1-1:0]     w_w;
    logic [CW1-1:0]     w_h;
    logic               w_inX;
    logic               w_inY;
    logic [COORD_W-1:0] w_col;
    logic [COORD_W-1:0] w_row;
    logic [COORD_W-1:0] w_colEff;
    logic [ADDR_W-1:0]  w_base;
    logic [ADDR_W-1:0]  w_frameWords;
    logic [ADDR_W-1:0]  w_pixAddr;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_on;
    logic [COORD_W-1:0] r_width;
    logic [COORD_W-1:0] r_height;

    anim_frame_seq #(
        .NUM_ANIMS  (NUM_ANIMS),
        .MAX_FRAMES (MAX_FRAMES),
        .FRAME_DIV  (FRAME_DIV)
    ) u_seq (
        .Clk        (Clk),
        .Reset      (Reset),
        .i_frameClk (frame_clk),
        .i_animSel  (anim_sel),
        .i_moving   (moving),
        .o_anim     (w_anim),
        .o_frameIdx (frameIdx),
        .o_animDone (animDone)
    );

    assign w_w          = CW1'(ANIM_W[w_anim]);
    assign w_h          = CW1'(ANIM_H[w_anim]);
    assign w_base       = ADDR_W'(ANIM_BASE[w_anim]);
    assign w_frameWords = ADDR_W'(ANIM_W[w_anim] * ANIM_H[w_anim]);

    // One extra bit so a sprite hanging off the right/bottom edge does not wrap to column 0.
    assign w_inX = ({1'b0, DrawX} >= {1'b0, PlayerX}) && ({1'b0, DrawX} < ({1'b0, PlayerX} + w_w));
    assign w_inY = ({1'b0, DrawY} >= {1'b0, PlayerY}) && ({1'b0, DrawY} < ({1'b0, PlayerY} + w_h));

    assign w_col    = DrawX - PlayerX;
    assign w_row    = DrawY - PlayerY;
    assign w_colEff = direction ? w_col : (COORD_W'(w_w - CW1'(1)) - w_col);

    assign w_pixAddr = w_base
                     + ADDR_W'(frameIdx) * w_frameWords
                     + ADDR_W'(w_row) * ADDR_W'(w_w)
                     + ADDR_W'(w_colEff);

    // Outside the box the address parks on the animation base so the ROM output stays quiet.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_on     <= 1'b0;
            r_addr   <= '0;
            r_width  <= '0;
            r_height <= '0;
        end else begin
            r_on     <= w_inX & w_inY;
            r_addr   <= (w_inX & w_inY) ? w_pixAddr : w_base;
            r_width  <= COORD_W'(ANIM_W[w_anim]);
            r_height <= COORD_W'(ANIM_H[w_anim]);
        end
    end

    assign spriteAddress = r_addr;
    assign spriteOn      = r_on;
    assign PlayerWidth   = r_width;
    assign PlayerHeight  = r_height;

endmodule

// File: tb/tb_player_sprite_animator.sv
// Scoreboard bench for player_sprite_animator: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_player_sprite_animator;

    localparam int F_FRAME  = 0;
    localparam int F_DONE   = 1;
    localparam int F_ON     = 2;
    localparam int F_ADDR   = 3;
    localparam int F_WIDTH  = 4;
    localparam int F_HEIGHT = 5;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        frame_clk;
    logic [2:0]  anim_sel;
    logic        moving;
    logic        direction;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic [9:0]  PlayerX;
    logic [9:0]  PlayerY;
    logic [20:0] spriteAddress;
    logic        spriteOn;
    logic [9:0]  PlayerWidth;
    logic [9:0]  PlayerHeight;
    logic [1:0]  frameIdx;
    logic        animDone;

    int    checks = 0;
    int    failures = 0;
    int    qField[$];
    int    qExp[$];
    string qLabel[$];

    player_sprite_animator dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .frame_clk     (frame_clk),
        .anim_sel      (anim_sel),
        .moving        (moving),
        .direction     (direction),
        .DrawX         (DrawX),
        .DrawY         (DrawY),
        .PlayerX       (PlayerX),
        .PlayerY       (PlayerY),
        .spriteAddress (spriteAddress),
        .spriteOn      (spriteOn),
        .PlayerWidth   (PlayerWidth),
        .PlayerHeight  (PlayerHeight),
        .frameIdx      (frameIdx),
        .animDone      (animDone)
    );

    always #5 Clk = ~Clk;

    function automatic string fieldName(input int f);
        case (f)
            F_FRAME:  return "frameIdx";
            F_DONE:   return "animDone";
            F_ON:     return "spriteOn";
            F_ADDR:   return "spriteAddress";
            F_WIDTH:  return "PlayerWidth";
            default:  return "PlayerHeight";
        endcase
    endfunction

    function automatic int actualOf(input int f);
        case (f)
            F_FRAME:  return int'(frameIdx);
            F_DONE:   return int'(animDone);
            F_ON:     return int'(spriteOn);
            F_ADDR:   return int'(spriteAddress);
            F_WIDTH:  return int'(PlayerWidth);
            default:  return int'(PlayerHeight);
        endcase
    endfunction

    always @(negedge Clk) begin : monitor
        int    f;
        int    e;
        int    a;
        string l;
        while (qField.size() > 0) begin
            f = qField.pop_front();
            e = qExp.pop_front();
            l = qLabel.pop_front();
            a = actualOf(f);
            checks++;
            if (a != e) begin
                failures++;
                $display("[TB] FAIL %s %s: got %0d, expected %0d", l, fieldName(f), a, e);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string label, input int field, input int expVal);
        qLabel.push_back(label);
        qField.push_back(field);
        qExp.push_back(expVal);
    endtask

    task automatic checkAllZero(input string label);
        checkOutput(label, F_FRAME, 0);
        checkOutput(label, F_DONE, 0);
        checkOutput(label, F_ON, 0);
        checkOutput(label, F_ADDR, 0);
        checkOutput(label, F_WIDTH, 0);
        checkOutput(label, F_HEIGHT, 0);
    endtask

    task automatic nextCycle();
        @(posedge Clk);
        #1;
    endtask

    // Each call produces exactly one frame_clk rising edge; returns just after the edge took effect.
    task automatic applyTicks(input int n);
        for (int i = 0; i < n; i++) begin
            nextCycle();
            frame_clk = 1'b1;
            nextCycle();
            frame_clk = 1'b0;
        end
    endtask

    task automatic applyStimulus(input int x, input int y, input logic dir);
        DrawX     = 10'(x);
        DrawY     = 10'(y);
        direction = dir;
        nextCycle();
    endtask

    task automatic checkPixel(input string label, input int x, input int y, input logic dir,
                              input int expOn, input int expAddr);
        applyStimulus(x, y, dir);
        checkOutput(label, F_ON, expOn);
        checkOutput(label, F_ADDR, expAddr);
    endtask

    initial begin : stimulus
        Reset     = 1'b1;
        frame_clk = 1'b0;
        anim_sel  = 3'd0;
        moving    = 1'b0;
        direction = 1'b1;
        DrawX     = '0;
        DrawY     = '0;
        PlayerX   = '0;
        PlayerY   = '0;
        repeat (3) nextCycle();
        checkAllZero("reset");
        nextCycle();
        Reset = 1'b0;

        // RUN loops over 3 frames, one step per 6 ticks
        moving   = 1'b1;
        anim_sel = 3'd1;
        nextCycle();
        nextCycle();
        checkOutput("t1 width", F_WIDTH, 32);
        checkOutput("t1 height", F_HEIGHT, 48);
        checkOutput("t1 start", F_FRAME, 0);
        for (int k = 1; k <= 36; k++) begin
            applyTicks(1);
            checkOutput($sformatf("t1 tick%0d", k), F_FRAME, (k / 6) % 3);
            checkOutput($sformatf("t1 tick%0d", k), F_DONE, 0);
        end

        // moving=0 freezes a looping animation, stepping resumes a full divide later
        moving = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            applyTicks(1);
            checkOutput($sformatf("t2 frozen%0d", k), F_FRAME, 0);
        end
        moving = 1'b1;
        applyTicks(5);
        checkOutput("t2 resume5", F_FRAME, 0);
        applyTicks(1);
        checkOutput("t2 resume6", F_FRAME, 1);

        // DEAD is one-shot with 4 frames and plays regardless of moving
        moving   = 1'b0;
        anim_sel = 3'd7;
        nextCycle();
        checkOutput("t3 start", F_FRAME, 0);
        checkOutput("t3 start", F_DONE, 0);
        nextCycle();
        checkOutput("t3 width", F_WIDTH, 48);
        checkOutput("t3 height", F_HEIGHT, 32);
        applyTicks(17);
        checkOutput("t3 tick17", F_FRAME, 2);
        checkOutput("t3 tick17", F_DONE, 0);
        applyTicks(1);
        checkOutput("t3 tick18", F_FRAME, 3);
        checkOutput("t3 tick18", F_DONE, 1);
        for (int k = 1; k <= 6; k++) begin
            applyTicks(1);
            checkOutput($sformatf("t3 hold%0d", k), F_FRAME, 3);
            checkOutput($sformatf("t3 hold%0d", k), F_DONE, 1);
        end
        anim_sel = 3'd0;
        nextCycle();
        checkOutput("t3 to WAIT", F_FRAME, 0);
        checkOutput("t3 to WAIT", F_DONE, 0);

        // anim change on the same cycle as a tick must win and clear the divider
        moving   = 1'b1;
        anim_sel = 3'd1;
        nextCycle();
        applyTicks(5);
        nextCycle();
        frame_clk = 1'b1;
        anim_sel  = 3'd7;
        nextCycle();
        frame_clk = 1'b0;
        checkOutput("t6 sametick", F_FRAME, 0);
        checkOutput("t6 sametick", F_DONE, 0);
        applyTicks(5);
        checkOutput("t6 div cleared", F_FRAME, 0);
        applyTicks(1);
        checkOutput("t6 first step", F_FRAME, 1);

        // Hit test and mirroring on RUN (base 3072, 32x48)
        anim_sel = 3'd1;
        PlayerX  = 10'd100;
        PlayerY  = 10'd200;
        nextCycle();
        checkOutput("t4 frame0", F_FRAME, 0);
        checkPixel("t4 x100 r", 100, 200, 1'b1, 1, 3072);
        checkPixel("t4 x131 r", 131, 200, 1'b1, 1, 3103);
        checkPixel("t4 x132 r", 132, 200, 1'b1, 0, 3072);
        checkPixel("t4 x100 l", 100, 200, 1'b0, 1, 3103);
        checkPixel("t4 x131 l", 131, 200, 1'b0, 1, 3072);
        checkPixel("t4 y199", 100, 199, 1'b1, 0, 3072);
        applyTicks(6);
        checkOutput("t4 frame1", F_FRAME, 1);
        checkPixel("t4 f1 r", 105, 201, 1'b1, 1, 4645);
        checkPixel("t4 f1 l", 105, 201, 1'b0, 1, 4666);
        checkPixel("t4 bottom", 100, 247, 1'b1, 1, 6112);
        checkPixel("t4 y248", 100, 248, 1'b1, 0, 3072);

        // Sprite past the right screen edge: no wraparound
        PlayerX = 10'd620;
        checkPixel("t5 x639", 639, 200, 1'b1, 1, 4627);
        checkPixel("t5 x0", 0, 200, 1'b1, 0, 3072);
        PlayerX = 10'd1000;
        checkPixel("t5 x1010", 1010, 200, 1'b1, 1, 4618);
        checkPixel("t5 x8", 8, 200, 1'b1, 0, 3072);

        // Asynchronous reset in the middle of RUN, compared before any further Clk edge
        checkPixel("t6 pre-reset", 1010, 200, 1'b1, 1, 4618);
        @(posedge Clk);
        #2;
        Reset = 1'b1;
        checkAllZero("t6 async reset");
        anim_sel = 3'd0;
        nextCycle();
        Reset = 1'b0;
        nextCycle();
        nextCycle();
        checkOutput("t6 after reset", F_FRAME, 0);
        checkOutput("t6 after reset", F_WIDTH, 32);
        checkOutput("t6 after reset", F_HEIGHT, 48);

        repeat (3) nextCycle();
        if (qField.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard drain: got %0d pending, expected 0", qField.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
